// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM: registered state, opcode/funct decode, memory
// handshake stall with timeout, illegal-instruction trap and retire counter.
`timescale 1ns/1ps
module multicycle_ctrl_fsm #(
  parameter int          MEM_HANDSHAKE = 1,
  parameter int unsigned TIMEOUT       = 15,
  parameter int unsigned WAIT_W        = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic [4:0]       state,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic [1:0]       alu_sel,
  output logic             instr_done,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [4:0] {
    S_IF        = 5'd0,  S_ID_1      = 5'd1,  S_ID_J      = 5'd2,
    S_ID_BNE    = 5'd3,  S_EX_OP_IMM = 5'd4,  S_EX_ADDI   = 5'd5,
    S_EX_A_OP_B = 5'd6,  S_EX_A_ADD0 = 5'd7,  S_EX_BNE    = 5'd8,
    S_MEM_READ  = 5'd9,  S_MEM_WRITE = 5'd10, S_WB_XORI   = 5'd11,
    S_WB_LW     = 5'd12, S_WB_ALU    = 5'd13, S_WB_JAL    = 5'd14,
    S_WB_JR     = 5'd15, S_TRAP      = 5'd16
  } state_t;

  localparam logic [5:0] OP_XORI = 6'b001110, OP_LW  = 6'b100011,
                         OP_SW   = 6'b101011, OP_RT  = 6'b000000,
                         OP_J    = 6'b000010, OP_JAL = 6'b000011,
                         OP_JR   = 6'b001000, OP_BNE = 6'b000101;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                         FN_SLT = 6'b101010;
  localparam logic [1:0] C_OPC = 2'b01, C_FUNCT = 2'b10, C_TMO = 2'b11;

  state_t            st, nxt;
  logic [1:0]        nxt_cause;
  logic [WAIT_W-1:0] waitcnt;
  logic              adv, is_mem, funct_ok;

  always_comb begin
    adv       = (MEM_HANDSHAKE == 0) || mem_ready;
    is_mem    = (st == S_IF) || (st == S_MEM_READ) || (st == S_MEM_WRITE);
    funct_ok  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
    nxt       = st;
    nxt_cause = 2'b00;
    case (st)
      S_IF: if (adv) begin
        case (opcode)
          OP_J, OP_JAL:                        nxt = S_ID_J;
          OP_BNE:                              nxt = S_ID_BNE;
          OP_XORI, OP_LW, OP_SW, OP_RT, OP_JR: nxt = S_ID_1;
          default: begin nxt = S_TRAP; nxt_cause = C_OPC; end
        endcase
      end
      S_ID_1: begin
        case (opcode)
          OP_XORI:      nxt = S_EX_OP_IMM;
          OP_LW, OP_SW: nxt = S_EX_ADDI;
          OP_JR:        nxt = S_EX_A_ADD0;
          OP_RT: begin
            if (funct_ok) nxt = S_EX_A_OP_B;
            else begin nxt = S_TRAP; nxt_cause = C_FUNCT; end
          end
          default: begin nxt = S_TRAP; nxt_cause = C_OPC; end
        endcase
      end
      S_ID_J:      nxt = (opcode == OP_JAL) ? S_WB_JAL : S_IF;
      S_ID_BNE:    nxt = S_EX_BNE;
      S_EX_OP_IMM: nxt = S_WB_XORI;
      S_EX_ADDI:   nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_EX_A_OP_B: nxt = S_WB_ALU;
      S_EX_A_ADD0: nxt = S_WB_JR;
      S_MEM_READ:  if (adv) nxt = S_WB_LW;
      S_MEM_WRITE: if (adv) nxt = S_IF;
      S_EX_BNE, S_WB_XORI, S_WB_LW, S_WB_ALU, S_WB_JAL, S_WB_JR: nxt = S_IF;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_IF;
    endcase
    // A ready arriving on the timeout cycle still advances: only !adv traps.
    if (is_mem && !adv && (TIMEOUT > 0) && (waitcnt == WAIT_W'(TIMEOUT))) begin
      nxt       = S_TRAP;
      nxt_cause = C_TMO;
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    alu_sel    = 2'b00;
    instr_done = 1'b0;
    case (st)
      S_IF:        begin mem_re = 1'b1; ir_we = 1'b1; pc_we = adv; end
      S_MEM_READ:  mem_re = 1'b1;
      S_MEM_WRITE: begin mem_we = 1'b1; instr_done = adv; end
      S_WB_XORI, S_WB_LW, S_WB_ALU, S_WB_JAL: begin
        reg_we = 1'b1; instr_done = 1'b1;
      end
      S_WB_JR:     begin pc_we = 1'b1; instr_done = 1'b1; end
      S_ID_J:      begin pc_we = 1'b1; instr_done = (opcode != OP_JAL); end
      S_EX_BNE:    begin pc_we = 1'b1; alu_sel = 2'b01; instr_done = 1'b1; end
      S_EX_OP_IMM: alu_sel = 2'b11;
      S_EX_A_OP_B: begin
        case (funct)
          FN_SUB:  alu_sel = 2'b01;
          FN_SLT:  alu_sel = 2'b10;
          default: alu_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IF;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      retired    <= '0;
      waitcnt    <= '0;
    end else begin
      st <= nxt;
      if (nxt == S_TRAP && st != S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= nxt_cause;
      end
      if (nxt != st)             waitcnt <= '0;
      else if (is_mem && !adv)   waitcnt <= waitcnt + WAIT_W'(1);
      if (instr_done)            retired <= retired + CNT_W'(1);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: default instance plus a
// TIMEOUT=3 / CNT_W=2 instance driven by the same directed vectors.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;
  logic clk = 1'b0, reset;
  logic [5:0] opcode, funct;
  logic mem_ready;

  logic [4:0]  a_state, b_state;
  logic        a_pc_we, a_ir_we, a_reg_we, a_mem_re, a_mem_we, a_done, a_trap;
  logic        b_pc_we, b_ir_we, b_reg_we, b_mem_re, b_mem_we, b_done, b_trap;
  logic [1:0]  a_alu, b_alu, a_cause, b_cause;
  logic [15:0] a_ret;
  logic [1:0]  b_ret;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm u_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .state(a_state), .pc_we(a_pc_we), .ir_we(a_ir_we), .reg_we(a_reg_we),
    .mem_re(a_mem_re), .mem_we(a_mem_we), .alu_sel(a_alu), .instr_done(a_done),
    .trap(a_trap), .trap_cause(a_cause), .retired(a_ret));

  multicycle_ctrl_fsm #(.TIMEOUT(3), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .state(b_state), .pc_we(b_pc_we), .ir_we(b_ir_we), .reg_we(b_reg_we),
    .mem_re(b_mem_re), .mem_we(b_mem_we), .alu_sel(b_alu), .instr_done(b_done),
    .trap(b_trap), .trap_cause(b_cause), .retired(b_ret));

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         J = 6'b000010, JAL = 6'b000011, JR = 6'b001000,
                         BNE = 6'b000101, XORI = 6'b001110, BAD = 6'b111111;
  localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_BAD = 6'b000111;
  // ctl = {pc_we, ir_we, reg_we, mem_re, mem_we, alu_sel[1:0], instr_done}
  localparam logic [7:0] C_IF = 8'hD0, C_IFW = 8'h50, C_Z = 8'h00, C_JD = 8'h81,
                         C_JA = 8'h80, C_IMM = 8'h06, C_SUB = 8'h02, C_SLT = 8'h04,
                         C_BNE = 8'h83, C_RD = 8'h10, C_WR = 8'h08, C_WRD = 8'h09,
                         C_WB = 8'h21;

  typedef struct {
    int         id;
    logic [4:0] sa, sb;
    logic [7:0] ctl;
    int         ra, rb;
    logic [2:0] ta, tb;
  } exp_t;

  exp_t q[$];
  int   ntests = 0, nfail = 0, nsteps = 0;

  task automatic chk(input string nm, input int id, input logic [15:0] act,
                     input logic [15:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state_a", e.id, 16'(a_state), 16'(e.sa));
      chk("state_b", e.id, 16'(b_state), 16'(e.sb));
      chk("ctl_a", e.id, 16'({a_pc_we, a_ir_we, a_reg_we, a_mem_re, a_mem_we, a_alu, a_done}),
          16'(e.ctl));
      chk("ctl_b", e.id, 16'({b_pc_we, b_ir_we, b_reg_we, b_mem_re, b_mem_we, b_alu, b_done}),
          (e.sb == 5'd16) ? 16'h0 : 16'(e.ctl));
      chk("retired_a", e.id, a_ret, 16'(e.ra));
      chk("retired_b", e.id, 16'(b_ret), 16'(e.rb[1:0]));
      chk("trap_a", e.id, 16'({a_trap, a_cause}), 16'(e.ta));
      chk("trap_b", e.id, 16'({b_trap, b_cause}), 16'(e.tb));
    end
  end

  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic [4:0] sa, input logic [4:0] sb,
                      input logic [7:0] ctl, input int ra, input int rb,
                      input logic [2:0] ta, input logic [2:0] tb);
    exp_t e;
    reset = rst; opcode = op; funct = fn; mem_ready = mr;
    e.id = nsteps; e.sa = sa; e.sb = sb; e.ctl = ctl;
    e.ra = ra; e.rb = rb; e.ta = ta; e.tb = tb;
    nsteps++;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic s(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                   input logic [4:0] st, input logic [7:0] ctl, input int ra, input int rb);
    step(1'b0, op, fn, mr, st, st, ctl, ra, rb, 3'b000, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; opcode = LW; funct = '0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step(1'b1, LW, 6'd0, 1'b1, 5'd0, 5'd0, C_IF, 0, 0, 3'b000, 3'b000);
    // LW, ready tied high
    s(LW, 0, 1, 0, C_IF, 0, 0);  s(LW, 0, 1, 1, C_Z, 0, 0);
    s(LW, 0, 1, 5, C_Z, 0, 0);   s(LW, 0, 1, 9, C_RD, 0, 0);
    s(LW, 0, 1, 12, C_WB, 0, 0);
    // SW stalled 3 cycles; instance b hits its timeout count as ready arrives
    s(SW, 0, 1, 0, C_IF, 1, 1);  s(SW, 0, 1, 1, C_Z, 1, 1);
    s(SW, 0, 1, 5, C_Z, 1, 1);
    for (int i = 0; i < 3; i++) s(SW, 0, 0, 10, C_WR, 1, 1);
    s(SW, 0, 1, 10, C_WRD, 1, 1);
    // J, JAL (b's 2-bit count wraps to 0 after JAL)
    s(J, 0, 1, 0, C_IF, 2, 2);   s(J, 0, 1, 2, C_JD, 2, 2);
    s(JAL, 0, 1, 0, C_IF, 3, 3); s(JAL, 0, 1, 2, C_JA, 3, 3);
    s(JAL, 0, 1, 14, C_WB, 3, 3);
    // R-type SUB, XORI, BNE, JR, R-type SLT
    s(RT, F_SUB, 1, 0, C_IF, 4, 0);  s(RT, F_SUB, 1, 1, C_Z, 4, 0);
    s(RT, F_SUB, 1, 6, C_SUB, 4, 0); s(RT, F_SUB, 1, 13, C_WB, 4, 0);
    s(XORI, 0, 1, 0, C_IF, 5, 1);  s(XORI, 0, 1, 1, C_Z, 5, 1);
    s(XORI, 0, 1, 4, C_IMM, 5, 1); s(XORI, 0, 1, 11, C_WB, 5, 1);
    s(BNE, 0, 1, 0, C_IF, 6, 2);   s(BNE, 0, 1, 3, C_Z, 6, 2);
    s(BNE, 0, 1, 8, C_BNE, 6, 2);
    s(JR, 0, 1, 0, C_IF, 7, 3);    s(JR, 0, 1, 1, C_Z, 7, 3);
    s(JR, 0, 1, 7, C_Z, 7, 3);     s(JR, 0, 1, 15, C_JD, 7, 3);
    s(RT, F_SLT, 1, 0, C_IF, 8, 0);  s(RT, F_SLT, 1, 1, C_Z, 8, 0);
    s(RT, F_SLT, 1, 6, C_SLT, 8, 0); s(RT, F_SLT, 1, 13, C_WB, 8, 0);
    // Illegal funct traps from ID_1; TRAP absorbs until reset
    s(RT, F_BAD, 1, 0, C_IF, 9, 1);  s(RT, F_BAD, 1, 1, C_Z, 9, 1);
    step(1'b0, XORI, 6'd0, 1'b1, 5'd16, 5'd16, C_Z, 9, 1, 3'b110, 3'b110);
    step(1'b1, XORI, 6'd0, 1'b1, 5'd16, 5'd16, C_Z, 9, 1, 3'b110, 3'b110);
    // Illegal opcode traps from IF
    s(BAD, 0, 1, 0, C_IF, 0, 0);
    step(1'b0, BAD, 6'd0, 1'b1, 5'd16, 5'd16, C_Z, 0, 0, 3'b101, 3'b101);
    step(1'b1, BAD, 6'd0, 1'b1, 5'd16, 5'd16, C_Z, 0, 0, 3'b101, 3'b101);
    // Ready stuck low in IF: b times out after 3 stall cycles, a keeps waiting
    for (int i = 0; i < 4; i++) s(LW, 0, 0, 0, C_IFW, 0, 0);
    step(1'b0, LW, 6'd0, 1'b0, 5'd0, 5'd16, C_IFW, 0, 0, 3'b000, 3'b111);
    step(1'b0, LW, 6'd0, 1'b1, 5'd0, 5'd16, C_IF, 0, 0, 3'b000, 3'b111);
    step(1'b0, LW, 6'd0, 1'b1, 5'd1, 5'd16, C_Z, 0, 0, 3'b000, 3'b111);
    step(1'b0, LW, 6'd0, 1'b1, 5'd5, 5'd16, C_Z, 0, 0, 3'b000, 3'b111);
    step(1'b0, LW, 6'd0, 1'b0, 5'd9, 5'd16, C_RD, 0, 0, 3'b000, 3'b111);
    step(1'b1, LW, 6'd0, 1'b0, 5'd9, 5'd16, C_RD, 0, 0, 3'b000, 3'b111);
    // After reset: wait counter starts clear and clears again on leaving IF
    s(LW, 0, 0, 0, C_IFW, 0, 0);  s(LW, 0, 0, 0, C_IFW, 0, 0);
    s(LW, 0, 1, 0, C_IF, 0, 0);   s(LW, 0, 1, 1, C_Z, 0, 0);
    s(LW, 0, 1, 5, C_Z, 0, 0);
    for (int i = 0; i < 3; i++) s(LW, 0, 0, 9, C_RD, 0, 0);
    s(LW, 0, 1, 9, C_RD, 0, 0);   s(LW, 0, 1, 12, C_WB, 0, 0);
    s(LW, 0, 1, 0, C_IF, 1, 1);
    @(negedge clk); #1;
    ntests++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
